// File: rtl/corner_stream_fifo_if.sv
// Stream bundle between a corner detector, the corner FIFO and its consumer.
// The slave modport is the FIFO's view of the bundle.
interface corner_stream_fifo_if #(
   parameter int unsigned COORD_WIDTH = 10,
   parameter int unsigned CNT_WIDTH   = 16
);
   logic                   ce;
   logic                   iscorner;
   logic [COORD_WIDTH-1:0] x_coord;
   logic [COORD_WIDTH-1:0] y_coord;
   logic                   m_valid;
   logic                   m_ready;
   logic [COORD_WIDTH-1:0] m_x;
   logic [COORD_WIDTH-1:0] m_y;
   logic                   m_corner;
   logic                   m_last;
   logic                   frame_done;
   logic [CNT_WIDTH-1:0]   frame_corners;
   logic [CNT_WIDTH-1:0]   frame_dropped;

   modport master (
      output ce, iscorner, x_coord, y_coord, m_ready,
      input  m_valid, m_x, m_y, m_corner, m_last, frame_done, frame_corners, frame_dropped
   );

   modport slave (
      input  ce, iscorner, x_coord, y_coord, m_ready,
      output m_valid, m_x, m_y, m_corner, m_last, frame_done, frame_corners, frame_dropped
   );
endinterface

// File: rtl/corner_stream_fifo.sv
// First-word-fall-through FIFO of detected corners with per-frame end markers and counters.
// The last slot is held back so the end-of-frame entry can always be queued.
module corner_stream_fifo #(
   parameter int unsigned COL_NUM     = 640,
   parameter int unsigned ROW_NUM     = 480,
   parameter int unsigned COORD_WIDTH = 10,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned MAX_CORNERS = 1023,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input logic                 clk,
   input logic                 rst,
   corner_stream_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = AW + 1;

   typedef struct packed {
      logic                   corner;
      logic                   last;
      logic [COORD_WIDTH-1:0] x;
      logic [COORD_WIDTH-1:0] y;
   } entry_t;

   entry_t               r_mem [DEPTH];
   logic [AW-1:0]        r_wptr, r_rptr;
   logic [OW-1:0]        r_count;
   logic [CNT_WIDTH-1:0] r_acc, r_drop, r_pend_acc, r_pend_drop;
   logic [CNT_WIDTH-1:0] r_frame_corners, r_frame_dropped;
   logic                 r_eof_pending, r_frame_done;

   logic                 w_valid, w_pop, w_push, w_eof, w_eof_now, w_corner;
   logic                 w_room_corner, w_room_eof, w_flush, w_accept, w_drop, w_marker, w_done;
   logic [CNT_WIDTH-1:0] w_acc_fin, w_drop_fin;
   entry_t               w_wdata, w_head;

   assign w_valid       = (r_count != '0);
   assign w_pop         = w_valid & bus.m_ready;
   assign w_eof         = bus.ce & (bus.x_coord == COORD_WIDTH'(COL_NUM - 1))
                                 & (bus.y_coord == COORD_WIDTH'(ROW_NUM - 1));
   assign w_corner      = bus.ce & bus.iscorner;
   // Occupancy tests use the pre-pop count.
   assign w_room_corner = (r_count <= OW'(DEPTH - 2));
   assign w_room_eof    = (r_count < OW'(DEPTH));
   assign w_flush       = r_eof_pending & w_room_eof;
   assign w_accept      = w_corner & ~r_eof_pending & w_room_corner
                                   & (r_acc < CNT_WIDTH'(MAX_CORNERS));
   assign w_drop        = w_corner & ~w_accept;
   assign w_eof_now     = w_eof & ~r_eof_pending;
   assign w_marker      = w_eof_now & ~w_accept & w_room_eof;
   assign w_push        = w_flush | w_accept | w_marker;
   assign w_done        = w_flush | (w_eof_now & w_room_eof);
   assign w_acc_fin     = w_accept ? r_acc + CNT_WIDTH'(1) : r_acc;
   assign w_drop_fin    = (w_drop && r_drop != '1) ? r_drop + CNT_WIDTH'(1) : r_drop;

   always_comb begin
      w_wdata.corner = 1'b0;
      w_wdata.last   = 1'b1;
      w_wdata.x      = COORD_WIDTH'(COL_NUM - 1);
      w_wdata.y      = COORD_WIDTH'(ROW_NUM - 1);
      if (!w_flush && w_accept) begin
         w_wdata.corner = 1'b1;
         w_wdata.last   = w_eof_now;
         w_wdata.x      = bus.x_coord;
         w_wdata.y      = bus.y_coord;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_count         <= '0;
         r_acc           <= '0;
         r_drop          <= '0;
         r_pend_acc      <= '0;
         r_pend_drop     <= '0;
         r_frame_corners <= '0;
         r_frame_dropped <= '0;
         r_eof_pending   <= 1'b0;
         r_frame_done    <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + OW'(1);
         else if (!w_push && w_pop) r_count <= r_count - OW'(1);
         r_frame_done <= w_done;
         if (w_flush) begin
            r_eof_pending   <= 1'b0;
            r_frame_corners <= r_pend_acc;
            r_frame_dropped <= r_pend_drop;
         end
         // Counters restart at every EOF beat; a stalled marker keeps its counts aside.
         if (w_eof_now) begin
            r_acc  <= '0;
            r_drop <= '0;
            if (w_room_eof) begin
               r_frame_corners <= w_acc_fin;
               r_frame_dropped <= w_drop_fin;
            end else begin
               r_eof_pending <= 1'b1;
               r_pend_acc    <= w_acc_fin;
               r_pend_drop   <= w_drop_fin;
            end
         end else begin
            r_acc  <= w_acc_fin;
            r_drop <= w_drop_fin;
         end
      end
   end

   assign w_head            = r_mem[r_rptr];
   assign bus.m_valid       = w_valid;
   assign bus.m_x           = w_valid ? w_head.x : '0;
   assign bus.m_y           = w_valid ? w_head.y : '0;
   assign bus.m_corner      = w_valid & w_head.corner;
   assign bus.m_last        = w_valid & w_head.last;
   assign bus.frame_done    = r_frame_done;
   assign bus.frame_corners = r_frame_corners;
   assign bus.frame_dropped = r_frame_dropped;
endmodule

// File: doc/corner_stream_fifo.md
CORNER_STREAM_FIFO -- requirements
Module: corner_stream_fifo

Interface -- parameters
REQ-001 SHALL have parameter COL_NUM, default 640: pixels per image row.
REQ-002 SHALL have parameter ROW_NUM, default 480: rows per frame.
REQ-003 SHALL have parameter COORD_WIDTH, default 10: width of x/y coordinates.
REQ-004 SHALL have parameter DEPTH, default 16: FIFO entries; power of 2, >= 4.
REQ-005 SHALL have parameter MAX_CORNERS, default 1023: maximum corners accepted per frame.
REQ-006 SHALL have parameter CNT_WIDTH, default 16: width of the per-frame counters.

Interface -- ports
REQ-007 SHALL have port clk, input, 1: single clock; all logic is clocked on the rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port ce, input, 1: the detector output beat is valid this cycle.
REQ-010 SHALL have port iscorner, input, 1: pixel at (x_coord, y_coord) is a corner after NMS.
REQ-011 SHALL have ports x_coord and y_coord, input, COORD_WIDTH each: pixel coordinates.
REQ-012 SHALL have port m_valid, output, 1: output entry available.
REQ-013 SHALL have port m_ready, input, 1: consumer accepts the entry.
REQ-014 SHALL have ports m_x and m_y, output, COORD_WIDTH each: entry coordinates.
REQ-015 SHALL have port m_corner, output, 1: entry is a corner (0 = end-of-frame marker only).
REQ-016 SHALL have port m_last, output, 1: entry is the last entry of its frame.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse when the end-of-frame entry is written.
REQ-018 SHALL have ports frame_corners and frame_dropped, output, CNT_WIDTH each: accepted and dropped counts of the last completed frame.

Function
REQ-019 Corner beat (ce & iscorner) SHALL be written when the pre-pop occupancy is <= DEPTH-2 and the frame's accepted count < MAX_CORNERS; otherwise it SHALL be dropped and the frame drop count incremented (saturating at 2^CNT_WIDTH-1).
REQ-020 The last FIFO slot SHALL be reserved for the end-of-frame entry; ordinary corners never fill it.
REQ-021 EOF beat SHALL be ce & x_coord==COL_NUM-1 & y_coord==ROW_NUM-1.
REQ-022 On an EOF beat with an accepted corner, a single entry SHALL be written with m_corner=1, m_last=1.
REQ-023 On an EOF beat without an accepted corner (none present or dropped), a marker SHALL be written with m_corner=0, m_last=1, m_x=COL_NUM-1, m_y=ROW_NUM-1.
REQ-024 If the marker cannot be written (FIFO full), eof_pending SHALL set and the marker SHALL be written on the first cycle with a free slot; corner beats arriving while pending SHALL be dropped and counted against the new frame.
REQ-025 When the end-of-frame entry is written: frame_done SHALL pulse for exactly that cycle; frame_corners/frame_dropped SHALL be loaded with the final counts; the per-frame counters SHALL clear.
REQ-026 Output SHALL be first-word-fall-through: a write to an empty FIFO gives m_valid=1 on the next cycle; latency is 1 cycle.
REQ-027 Pop SHALL occur when m_valid & m_ready; simultaneous push and pop SHALL keep occupancy unchanged; m_* outputs SHALL stay stable while m_valid=1 and m_ready=0.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a log2(DEPTH)+1-bit counter.
REQ-029 Beats with ce=0 SHALL be ignored regardless of iscorner and coordinates.

Reset
REQ-030 With rst=1 at a clock edge: FIFO emptied and pointers zeroed; m_valid=0; m_x, m_y, m_corner, m_last = 0; frame_done=0; frame_corners and frame_dropped = 0; eof_pending cleared; per-frame counters cleared.
REQ-031 Reset mid-frame SHALL discard all buffered entries and partial counts; the first ce beat after reset starts a new frame.

Verification
REQ-032 COL_NUM=8, ROW_NUM=4, DEPTH=4, m_ready=1; corners at (2,1) and (5,2) -> two entries with m_corner=1, m_last=0, then a marker (7,3) with m_corner=0, m_last=1; frame_done pulses once; frame_corners=2, frame_dropped=0.
REQ-033 m_ready=0; 5 consecutive corner beats -> 3 accepted, 2 dropped; at EOF the marker fills the 4th slot; frame_dropped=2.
REQ-034 Corner at (7,3) -> single entry with m_corner=1, m_last=1; no separate marker.
REQ-035 MAX_CORNERS=2; 3 corners with m_ready=1 -> third dropped; frame_corners=2, frame_dropped=1; counters are 0 at the start of the next frame.
REQ-036 FIFO full at EOF and m_ready=0 for 3 cycles -> frame_done stays low; raise m_ready -> marker written the cycle after the first pop, and frame_done pulses.
REQ-037 Assert rst with 2 entries buffered -> m_valid=0 on the next cycle, and both counter outputs read 0.
